// File: rtl/mac_unit_vert_seq.sv
// mac_unit_vert_seq: self-sequencing 16-lane vertical bit-serial MAC with group complement and valid/ready handshakes
module mac_unit_vert_seq #(
  parameter int DATA_WIDTH = 8,
  parameter int VEC_LENGTH = 16,
  parameter int GROUP_SIZE = 8,
  parameter int WEIGHT_BITS = 8,
  parameter int ACC_WIDTH = 32,
  localparam int NUM_GROUPS = VEC_LENGTH / GROUP_SIZE,
  localparam int COL_W = $clog2(WEIGHT_BITS)
) (
  input  logic clk,
  input  logic reset,
  input  logic act_valid,
  output logic act_ready,
  input  logic [VEC_LENGTH-1:0][DATA_WIDTH-1:0] act,
  input  logic act_last,
  input  logic col_valid,
  output logic col_ready,
  input  logic [VEC_LENGTH-1:0] col_mask,
  input  logic [NUM_GROUPS-1:0] col_inv,
  input  logic [COL_W-1:0] col_idx,
  input  logic col_end,
  output logic out_valid,
  input  logic out_ready,
  output logic [ACC_WIDTH-1:0] result
);
  localparam int GS_W = DATA_WIDTH + $clog2(GROUP_SIZE) + 1;
  localparam int CS_W = DATA_WIDTH + $clog2(VEC_LENGTH) + 1;
  typedef enum logic [1:0] {LOAD, COL, DRAIN, OUT} state_t;
  state_t state;
  logic last_q, stg_v;
  logic [VEC_LENGTH-1:0][DATA_WIDTH-1:0] act_q;
  logic signed [GS_W-1:0] gsum_d [NUM_GROUPS];
  logic signed [GS_W-1:0] gsum_q [NUM_GROUPS];
  logic signed [GS_W-1:0] msum;
  logic signed [CS_W-1:0] colsum;
  logic signed [ACC_WIDTH-1:0] colval, stg, acc, acc_nxt;
  // full group sums of the incoming vector, needed later for complemented columns
  always_comb begin
    for (int g = 0; g < NUM_GROUPS; g++) begin
      gsum_d[g] = '0;
      for (int l = 0; l < GROUP_SIZE; l++)
        gsum_d[g] = gsum_d[g] + GS_W'($signed(act[g*GROUP_SIZE+l]));
    end
  end
  // column sum from registered operands only, MSB column negated, then weighted by its bit position
  always_comb begin
    colsum = '0;
    msum = '0;
    for (int g = 0; g < NUM_GROUPS; g++) begin
      msum = '0;
      for (int l = 0; l < GROUP_SIZE; l++)
        if (col_mask[g*GROUP_SIZE+l]) msum = msum + GS_W'($signed(act_q[g*GROUP_SIZE+l]));
      colsum = colsum + CS_W'(col_inv[g] ? gsum_q[g] - msum : msum);
    end
    colval = ACC_WIDTH'(col_idx == COL_W'(WEIGHT_BITS - 1) ? -colsum : colsum) << col_idx;
    acc_nxt = acc + (stg_v ? stg : '0);
  end
  // activation vector and its group sums, held for the whole column phase
  always_ff @(posedge clk)
    if (act_valid && act_ready) begin
      act_q <= act;
      gsum_q <= gsum_d;
    end
  // control FSM, pipeline stage, accumulator and registered handshake outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= LOAD;
      act_ready <= 1'b0;
      col_ready <= 1'b0;
      out_valid <= 1'b0;
      result <= '0;
      acc <= '0;
      stg <= '0;
      stg_v <= 1'b0;
      last_q <= 1'b0;
    end else begin
      acc <= acc_nxt;
      stg_v <= 1'b0;
      case (state)
        LOAD: begin
          act_ready <= 1'b1;
          if (act_valid && act_ready) begin
            last_q <= act_last;
            act_ready <= 1'b0;
            col_ready <= 1'b1;
            state <= COL;
          end
        end
        COL:
          if (col_valid && col_ready) begin
            stg <= colval;
            stg_v <= 1'b1;
            if (col_end) begin
              col_ready <= 1'b0;
              act_ready <= !last_q;
              state <= last_q ? DRAIN : LOAD;
            end
          end
        DRAIN: begin
          result <= acc_nxt;
          out_valid <= 1'b1;
          state <= OUT;
        end
        default:
          if (out_ready) begin
            out_valid <= 1'b0;
            result <= '0;
            acc <= '0;
            act_ready <= 1'b1;
            state <= LOAD;
          end
      endcase
    end
  end
endmodule

// File: tb/tb_mac_unit_vert_seq.sv
// tb_mac_unit_vert_seq: table-driven and scoreboard-checked bench for the vertical bit-serial MAC
module tb_mac_unit_vert_seq;
  localparam int DW = 8, VL = 16, GS = 8, NG = 2, WB = 8, CW = 3, AW = 32;
  logic clk = 1'b0, reset = 1'b0;
  logic act_valid = 1'b0, act_ready, act_last = 1'b0;
  logic [VL-1:0][DW-1:0] act = '0;
  logic col_valid = 1'b0, col_ready, col_end = 1'b0;
  logic [VL-1:0] col_mask = '0;
  logic [NG-1:0] col_inv = '0;
  logic [CW-1:0] col_idx = '0;
  logic out_valid, out_ready = 1'b1;
  logic [AW-1:0] result;
  int checks = 0, errors = 0;
  logic signed [AW-1:0] sb[$];
  typedef struct {
    logic [VL-1:0][DW-1:0] a;
    logic [VL-1:0][WB-1:0] w;
    bit last;
    bit inv;
    int exp;
  } vec_t;
  vec_t tbl[9];

  always #5 clk = ~clk;

  mac_unit_vert_seq dut (
    .clk(clk), .reset(reset),
    .act_valid(act_valid), .act_ready(act_ready), .act(act), .act_last(act_last),
    .col_valid(col_valid), .col_ready(col_ready), .col_mask(col_mask), .col_inv(col_inv),
    .col_idx(col_idx), .col_end(col_end),
    .out_valid(out_valid), .out_ready(out_ready), .result(result)
  );

  task automatic chk(input string name, input logic signed [63:0] got, input logic signed [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, got, want);
    end
  endtask

  always @(negedge clk)
    if (reset && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL result_unexpected got %0d want none", $signed(result));
      end else chk("result", $signed(result), sb.pop_front());
    end

  task automatic wait_sig(input int which, input string name);
    int n = 0;
    while (!(which == 0 ? act_ready : which == 1 ? col_ready : out_valid) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n == 100) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout got 0 want 1", name);
    end
  endtask

  task automatic load(input logic [VL-1:0][DW-1:0] a, input bit last);
    wait_sig(0, "act_ready");
    act = a;
    act_last = last;
    act_valid = 1'b1;
    @(negedge clk);
    act_valid = 1'b0;
  endtask

  task automatic beat(input logic [VL-1:0] m, input logic [NG-1:0] inv, input int idx, input bit e);
    wait_sig(1, "col_ready");
    col_mask = m;
    col_inv = inv;
    col_idx = CW'(idx);
    col_end = e;
    col_valid = 1'b1;
    @(negedge clk);
    col_valid = 1'b0;
    col_end = 1'b0;
  endtask

  task automatic send_vec(input logic [VL-1:0][DW-1:0] a, input logic [VL-1:0][WB-1:0] w, input bit last, input bit use_inv);
    int lastcol = -1;
    logic [VL-1:0] m;
    logic [NG-1:0] inv;
    load(a, last);
    for (int b = 0; b < WB; b++)
      for (int i = 0; i < VL; i++)
        if (w[i][b]) lastcol = b;
    if (lastcol < 0) beat('0, '0, 0, 1'b1);
    for (int b = 0; b <= lastcol; b++) begin
      m = '0;
      inv = '0;
      for (int i = 0; i < VL; i++) m[i] = w[i][b];
      if (m != '0) begin
        if (use_inv)
          for (int g = 0; g < NG; g++)
            if ($countones(m[g*GS+:GS]) > GS / 2) begin
              inv[g] = 1'b1;
              m[g*GS+:GS] = ~m[g*GS+:GS];
            end
        beat(m, inv, b, b == lastcol);
      end
    end
  endtask

  function automatic longint dot(input logic [VL-1:0][DW-1:0] a, input logic [VL-1:0][WB-1:0] w);
    longint s = 0;
    for (int i = 0; i < VL; i++) s += longint'($signed(a[i])) * longint'($signed(w[i]));
    return s;
  endfunction

  function automatic vec_t mk(input int av, input int wv, input bit last, input bit inv, input int exp);
    vec_t v;
    for (int i = 0; i < VL; i++) begin
      v.a[i] = DW'(av);
      v.w[i] = WB'(wv);
    end
    v.last = last;
    v.inv = inv;
    v.exp = exp;
    return v;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

  initial begin
    logic [VL-1:0][DW-1:0] a;
    logic [VL-1:0][WB-1:0] w;
    logic signed [AW-1:0] hold;
    longint sum;
    int nv;
    tbl[0] = mk(1, -1, 1, 0, -16);
    tbl[1] = mk(2, 0, 1, 0, -256);
    tbl[1].w[0] = 8'h80;
    tbl[2] = mk(1, 1, 0, 0, 0);
    tbl[3] = mk(3, 2, 1, 1, 112);
    tbl[4] = mk(1, 1, 1, 0, 16);
    tbl[5] = mk(-8, 127, 1, 1, -16256);
    tbl[6] = mk(-128, -128, 1, 1, 262144);
    tbl[7] = mk(127, -128, 1, 0, -260096);
    tbl[8] = mk(5, 0, 1, 0, 0);
    repeat (3) @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_result", $signed(result), 0);
    chk("rst_col_ready", col_ready, 0);
    reset = 1'b1;
    @(negedge clk);
    chk("rel_act_ready", act_ready, 1);
    chk("rel_col_ready", col_ready, 0);
    for (int k = 0; k < 9; k++) begin
      if (tbl[k].last) sb.push_back(AW'(tbl[k].exp));
      send_vec(tbl[k].a, tbl[k].w, tbl[k].last, tbl[k].inv);
      if (k == 0) begin
        chk("drain_gap", out_valid, 0);
        @(negedge clk);
        chk("out_valid_2cyc", out_valid, 1);
      end
    end
    sb.push_back(AW'(360));
    for (int i = 0; i < VL; i++) a[i] = DW'(i);
    load(a, 1'b1);
    beat('1, 2'b00, 0, 1'b0);
    beat('0, 2'b11, 1, 1'b1);
    for (int r = 0; r < 6; r++) begin
      nv = $urandom_range(1, 3);
      sum = 0;
      for (int v = 0; v < nv; v++) begin
        for (int i = 0; i < VL; i++) begin
          a[i] = DW'($urandom);
          w[i] = WB'($urandom);
        end
        sum += dot(a, w);
        if (v == nv - 1) sb.push_back(AW'(sum));
        send_vec(a, w, v == nv - 1, 1'($urandom));
      end
    end
    wait_sig(0, "act_ready");
    out_ready = 1'b0;
    sb.push_back(AW'(16));
    send_vec(tbl[4].a, tbl[4].w, 1'b1, 1'b0);
    wait_sig(2, "out_valid");
    hold = result;
    for (int c = 0; c < 5; c++) begin
      chk("bp_out_valid", out_valid, 1);
      chk("bp_result_stable", $signed(result), hold);
      chk("bp_act_ready", act_ready, 0);
      chk("bp_col_ready", col_ready, 0);
      @(negedge clk);
    end
    @(posedge clk) #1 out_ready = 1'b1;
    @(posedge clk) #1;
    chk("post_hs_out_valid", out_valid, 0);
    chk("post_hs_result", $signed(result), 0);
    chk("post_hs_act_ready", act_ready, 1);
    @(negedge clk);
    load(tbl[0].a, 1'b1);
    for (int b = 0; b < 3; b++) beat('1, 2'b00, b, 1'b0);
    reset = 1'b0;
    @(negedge clk);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_col_ready", col_ready, 0);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_act_ready", act_ready, 1);
    sb.push_back(AW'(16));
    send_vec(tbl[4].a, tbl[4].w, 1'b1, 1'b0);
    for (int n = 0; n < 100 && sb.size() != 0; n++) @(negedge clk);
    chk("sb_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mac_unit_vert_seq.md
# mac_unit_vert_seq

Parametrised, self-sequencing successor of the 16-lane vertical bit-serial MAC. It processes one activation vector against a bit-sparse weight vector, one weight bit-column per beat. Each column is summed either directly or by group complement, then shifted by its column index and negated when it is the MSB column. Results accumulate across vectors until a last flag, and the dot product is returned over a valid/ready output handshake. The block sits between the activation buffer/column encoder and the PE-array output collector.

## Interface
- DATA_WIDTH, 8, signed activation width
- VEC_LENGTH, 16, activations per vector
- GROUP_SIZE, 8, lanes per complement group; VEC_LENGTH % GROUP_SIZE == 0; NUM_GROUPS = VEC_LENGTH/GROUP_SIZE
- WEIGHT_BITS, 8, weight precision (two's complement); COL_W = $clog2(WEIGHT_BITS)
- ACC_WIDTH, 32, accumulator/result width; must be >= DATA_WIDTH+$clog2(VEC_LENGTH)+WEIGHT_BITS
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset
- act_valid / act_ready  in / out  1  activation vector handshake
- act  in  VEC_LENGTH x DATA_WIDTH  signed activations
- act_last  in  1  vector is the last of the current dot product
- col_valid / col_ready  in / out  1  column beat handshake
- col_mask  in  VEC_LENGTH  per-lane select bit
- col_inv  in  NUM_GROUPS  per-group complement mode
- col_idx  in  COL_W  bit position of this column (0 = LSB)
- col_end  in  1  last column beat for the current vector
- out_valid / out_ready  out / in  1  result handshake
- result  out  ACC_WIDTH  signed dot product

## Operation
- The FSM has four states: LOAD, COL, DRAIN and OUT. Reset enters LOAD.
- **LOAD**
  - act_ready=1.
  - On an act handshake: register act, register act_last, register each group sum gsum[g] (width DATA_WIDTH+$clog2(GROUP_SIZE)+1), then go to COL.
- **COL**
  - col_ready=1.
  - For each accepted beat, per group g: msum[g] = sum of act lanes in g with col_mask=1.
  - term[g] = col_inv[g] ? gsum[g] - msum[g] : msum[g].
  - colsum = sum over g of term[g], signed, width DATA_WIDTH+$clog2(VEC_LENGTH)+1.
  - If col_idx == WEIGHT_BITS-1, colsum is negated.
  - The value is then shifted left by col_idx, sign-extended to ACC_WIDTH, and loaded into a single pipeline stage (stg, stg_v).
  - Next cycle: acc <= acc + stg.
  - Transitions on a beat with col_end=1: registered act_last=1 goes to DRAIN; otherwise to LOAD.
- **DRAIN**
  - Both readies are 0.
  - The final stg is added to acc. Go to OUT.
- **OUT**
  - out_valid=1, result=acc.
  - On the out handshake: acc <= 0, then go to LOAD.
- **Column beats**
  - Columns whose weight bits are all zero may be omitted.
  - col_idx must be strictly increasing within a vector. This is the source's responsibility and is not checked.
  - Every vector needs at least one beat with col_end=1. An all-zero mask with col_inv=0 contributes 0.
- **Arithmetic**
  - Group and column sums are exact.
  - The accumulator wraps modulo 2^ACC_WIDTH, with no saturation.
- **Ignored inputs**
  - col_valid is ignored outside COL.
  - act_valid is ignored outside LOAD.
  - out_ready is ignored outside OUT.

## Timing
- Reset, sampled on a clk edge with reset=0, sets:
  - state=LOAD, acc=0, stg=0, stg_v=0.
  - Outputs: out_valid=0, result=0, act_ready=1 from the cycle after reset is released, col_ready=0.
- A reset mid-operation aborts immediately and discards partial sums.
- An act handshake at edge E gives col_ready=1 in the cycle after E. There is no combinational path from act to the column datapath.
- One column beat is accepted per cycle, with no bubbles while col_valid=1.
- A column beat at edge E updates acc at edge E+1.
- The last beat of a last vector at edge E: DRAIN during cycle E..E+1, out_valid=1 from edge E+1, result includes every column.
- A non-last vector returns to LOAD right after its col_end beat. The next act handshake may coincide with the acc update of the previous final beat; both take effect.
- result and out_valid are held stable while out_ready=0.
- out handshake at edge E: out_valid=0 and act_ready=1 after E, result=0.
- Readies depend only on state (registered). out_valid/result are registered.

## Test plan
- **MSB negation.** All act=1; columns 0..7 all masks 1 (weight -1); act_last=1. Required: result=-16, out_valid 2 cycles after the col_end beat.
- **Group complement.** act[i]=i; weight 3 for all lanes.
  - Col 0: mask all 1, col_inv=0.
  - Col 1: mask all 0, col_inv=all 1, col_end.
  - Required: result=360.
- **Sparse column skip.** All act=2; single beat col_idx=7, mask lane 0 only, col_end. Required: result=-256.
- **Multi-vector accumulation.**
  - Vector A (all 1, weight 1) then vector B (all 3, weight 2, act_last).
  - Required: result=16+96=112.
  - A following single-vector dot product (all 1, weight 1) must give 16, proving acc was cleared.
- **Output backpressure.** Hold out_ready=0 for 5 cycles. Required: out_valid=1 and result constant, act_ready=col_ready=0 throughout, handshake on cycle 6.
- **Reset mid-column.** Assert reset=0 after 3 of 8 beats. Required: next cycle out_valid=0, col_ready=0, act_ready=1 after release; a fresh dot product yields an exact result with no residue.
